// File: rtl/wormhole_switch_allocator_pkg.sv
// Shared constants and types for the rr_router switch allocator.
// Port indices follow the router's mesh direction numbering.
package wormhole_switch_allocator_pkg;

  localparam int NUM_PORTS_DEF = 5;
  localparam int BITS_DIR      = 3;

  localparam logic [BITS_DIR-1:0] PORT_LOCAL = 3'd0;
  localparam logic [BITS_DIR-1:0] PORT_NORTH = 3'd1;
  localparam logic [BITS_DIR-1:0] PORT_SOUTH = 3'd2;
  localparam logic [BITS_DIR-1:0] PORT_EAST  = 3'd3;
  localparam logic [BITS_DIR-1:0] PORT_WEST  = 3'd4;

  typedef enum logic {
    OUT_IDLE   = 1'b0,
    OUT_LOCKED = 1'b1
  } lock_state_e;

endpackage

// File: rtl/wormhole_switch_allocator_output_lock_arbiter.sv
// One output port: IDLE/LOCKED wormhole lock plus round-robin pointer.
// Grants are combinational from the registered lock state.
module output_lock_arbiter
  import wormhole_switch_allocator_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DIR_BITS  = BITS_DIR,
  parameter int OUT_IDX   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid_i,
  input  logic [NUM_PORTS*DIR_BITS-1:0] req_dir_i,
  input  logic [NUM_PORTS-1:0]          req_tail_i,
  input  logic [NUM_PORTS-1:0]          owned_i,
  input  logic                          busy_i,
  output logic [NUM_PORTS-1:0]          grant_o,
  output logic                          valid_o,
  output logic                          locked_o,
  output logic [DIR_BITS-1:0]           owner_o
);

  lock_state_e          state_q, state_d;
  logic [DIR_BITS-1:0]  owner_q, owner_d;
  logic [DIR_BITS-1:0]  ptr_q, ptr_d;
  logic [NUM_PORTS-1:0] cand;
  logic                 found_hi, found_lo;
  logic [DIR_BITS-1:0]  win_hi, win_lo, win;
  logic                 fire;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand[i] = req_valid_i[i] && !owned_i[i] &&
        (req_dir_i[i*DIR_BITS +: DIR_BITS] == DIR_BITS'(OUT_IDX));
    end
  end

  // Lowest candidate above ptr wins; otherwise wrap to lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found_lo = 1'b1;
        win_lo   = DIR_BITS'(i);
        if (DIR_BITS'(i) > ptr_q) begin
          found_hi = 1'b1;
          win_hi   = DIR_BITS'(i);
        end
      end
    end
    win = found_hi ? win_hi : win_lo;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    fire    = 1'b0;
    grant_o = '0;
    unique case (state_q)
      OUT_IDLE: begin
        if (found_lo) begin
          state_d = OUT_LOCKED;
          owner_d = win;
          ptr_d   = win;
        end
      end
      OUT_LOCKED: begin
        fire = req_valid_i[owner_q] && !busy_i;
        grant_o[owner_q] = fire;
        if (fire && req_tail_i[owner_q]) state_d = OUT_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OUT_IDLE;
      owner_q <= '0;
      ptr_q   <= DIR_BITS'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign valid_o  = fire;
  assign locked_o = (state_q == OUT_LOCKED);
  assign owner_o  = locked_o ? owner_q : '0;

endmodule

// File: rtl/wormhole_switch_allocator.sv
// Wormhole switch allocator: one lock arbiter per output, an input
// may own at most one output at a time.
module wormhole_switch_allocator
  import wormhole_switch_allocator_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int DIR_BITS  = BITS_DIR
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*DIR_BITS-1:0] req_dir,
  input  logic [NUM_PORTS-1:0]          req_tail,
  input  logic [NUM_PORTS-1:0]          out_busy,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*DIR_BITS-1:0] out_sel,
  output logic                          err_bad_dir
);

  logic [NUM_PORTS-1:0] locked;
  logic [NUM_PORTS-1:0] owned;
  logic [NUM_PORTS-1:0] gnt_m [NUM_PORTS];
  logic [DIR_BITS-1:0]  owner [NUM_PORTS];
  logic                 bad_dir;
  logic                 err_q, err_d;

  // Built from registered lock state only, so no combinational loop.
  always_comb begin
    owned = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (locked[o] && owner[o] == DIR_BITS'(i)) owned[i] = 1'b1;
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    output_lock_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .DIR_BITS  (DIR_BITS),
      .OUT_IDX   (o)
    ) u_arb (
      .clk         (clk),
      .reset       (reset),
      .req_valid_i (req_valid),
      .req_dir_i   (req_dir),
      .req_tail_i  (req_tail),
      .owned_i     (owned),
      .busy_i      (out_busy[o]),
      .grant_o     (gnt_m[o]),
      .valid_o     (out_valid[o]),
      .locked_o    (locked[o]),
      .owner_o     (owner[o])
    );
    assign out_sel[o*DIR_BITS +: DIR_BITS] = owner[o];
  end

  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) grant = grant | gnt_m[o];
  end

  always_comb begin
    bad_dir = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_valid[i] &&
          req_dir[i*DIR_BITS +: DIR_BITS] >= DIR_BITS'(NUM_PORTS))
        bad_dir = 1'b1;
    end
    err_d = err_q | bad_dir;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_bad_dir = err_q;

endmodule

// File: tb/tb_wormhole_switch_allocator.sv
// Directed bench for the wormhole switch allocator with a small
// packet driver that pops flits on grant.
module tb_wormhole_switch_allocator;

  logic        clk;
  logic        reset;
  logic [4:0]  rv, rt, busy;
  logic [14:0] rdir;
  logic [4:0]  grant, out_valid;
  logic [14:0] out_sel;
  logic        err;

  int         n_chk = 0;
  int         n_pass = 0;
  int         rem [5];
  int         plen [5];
  logic [4:0] rep;
  logic       dup;

  wormhole_switch_allocator dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (rv),
    .req_dir     (rdir),
    .req_tail    (rt),
    .out_busy    (busy),
    .grant       (grant),
    .out_valid   (out_valid),
    .out_sel     (out_sel),
    .err_bad_dir (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [2:0] sel(input int o);
    return out_sel[o*3 +: 3];
  endfunction

  task automatic expg(input string tag, input logic [4:0] eg,
                      input logic [4:0] ev);
    check({tag, "/grant"}, grant, eg);
    check({tag, "/valid"}, out_valid, ev);
  endtask

  task automatic start_pkt(input int i, input int d, input int len);
    rdir[i*3 +: 3] = 3'(d);
    rem[i]  = len;
    plen[i] = len;
    rv[i]   = 1'b1;
    rt[i]   = (len == 1);
  endtask

  task automatic kill(input int i);
    rem[i] = 0;
    rv[i]  = 1'b0;
    rt[i]  = 1'b0;
    rep[i] = 1'b0;
  endtask

  task automatic next_cycle();
    logic [4:0] g;
    g = grant;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (g[i] && rem[i] > 0) begin
        rem[i]--;
        if (rem[i] == 0 && rep[i]) rem[i] = plen[i];
      end
      rv[i] = (rem[i] > 0);
      rt[i] = (rem[i] == 1);
    end
  endtask

  task automatic step();
    next_cycle();
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      dup = 1'b0;
      for (int o = 0; o < 5; o++)
        for (int p = o + 1; p < 5; p++)
          if (out_valid[o] && out_valid[p] && sel(o) == sel(p))
            dup = 1'b1;
      check("inv_cnt", $countones(grant), $countones(out_valid));
      check("inv_own", dup, 0);
    end
  end

  initial begin
    reset = 1'b1;
    rv = '0; rt = '0; busy = '0; rdir = '0; rep = '0;
    for (int i = 0; i < 5; i++) begin
      rem[i] = 0;
      plen[i] = 0;
    end
    repeat (2) next_cycle();
    #1;
    expg("rst", 0, 0);
    check("rst_sel", out_sel, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    start_pkt(0, 2, 1);
    #1;
    expg("sf_alloc", 0, 0);
    step();
    expg("sf_grant", 5'b00001, 5'b00100);
    check("sf_sel", out_sel, 0);
    next_cycle();
    start_pkt(1, 2, 1);
    #1;
    expg("sf_idle", 0, 0);
    step();
    expg("sf_realloc", 5'b00010, 5'b00100);
    check("sf_sel1", sel(2), 1);
    step();
    expg("sf_done", 0, 0);

    next_cycle();
    start_pkt(1, 4, 3);
    start_pkt(3, 4, 3);
    #1;
    expg("ct_alloc", 0, 0);
    repeat (3) begin
      step();
      expg("ct_in1", 5'b00010, 5'b10000);
      check("ct_sel1", sel(4), 1);
    end
    step();
    expg("ct_alloc3", 0, 0);
    repeat (3) begin
      step();
      expg("ct_in3", 5'b01000, 5'b10000);
      check("ct_sel3", sel(4), 3);
    end
    next_cycle();
    start_pkt(2, 4, 1);
    start_pkt(4, 4, 1);
    #1;
    expg("ct_ptr_alloc", 0, 0);
    step();
    expg("ct_ptr_in4", 5'b10000, 5'b10000);
    step();
    expg("ct_alloc2", 0, 0);
    step();
    expg("ct_in2", 5'b00100, 5'b10000);
    step();
    expg("ct_done", 0, 0);

    next_cycle();
    start_pkt(0, 1, 6);
    #1;
    expg("bp_alloc", 0, 0);
    repeat (2) begin
      step();
      expg("bp_flit", 5'b00001, 5'b00010);
    end
    next_cycle();
    busy = 5'b00010;
    start_pkt(2, 1, 1);
    #1;
    expg("bp_busy", 0, 0);
    repeat (3) begin
      step();
      expg("bp_busy", 0, 0);
    end
    next_cycle();
    busy = '0;
    #1;
    expg("bp_resume", 5'b00001, 5'b00010);
    check("bp_sel", sel(1), 0);
    repeat (3) begin
      step();
      expg("bp_flit2", 5'b00001, 5'b00010);
    end
    step();
    expg("bp_alloc2", 0, 0);
    step();
    expg("bp_in2", 5'b00100, 5'b00010);
    check("bp_sel2", sel(1), 2);
    step();
    expg("bp_done", 0, 0);

    next_cycle();
    start_pkt(0, 1, 1);
    start_pkt(2, 3, 1);
    start_pkt(4, 0, 1);
    #1;
    expg("io_alloc", 0, 0);
    step();
    expg("io_grant", 5'b10101, 5'b01011);
    check("io_sel", out_sel, 15'd1028);
    step();
    expg("io_done", 0, 0);

    next_cycle();
    for (int i = 0; i < 5; i++) start_pkt(i, 0, 1);
    rep = 5'h1f;
    #1;
    expg("fr_alloc", 0, 0);
    for (int k = 0; k < 6; k++) begin
      step();
      expg("fr_grant", 5'(1 << (k % 5)), 5'b00001);
      check("fr_sel", sel(0), k % 5);
      if (k < 5) begin
        step();
        expg("fr_alloc", 0, 0);
      end
    end
    next_cycle();
    for (int i = 0; i < 5; i++) kill(i);
    #1;
    expg("fr_done", 0, 0);

    next_cycle();
    start_pkt(2, 6, 1);
    #1;
    expg("bd_req", 0, 0);
    check("bd_err0", err, 0);
    step();
    expg("bd_nogrant", 0, 0);
    check("bd_err1", err, 1);
    next_cycle();
    kill(2);
    #1;
    check("bd_sticky", err, 1);
    next_cycle();
    start_pkt(0, 3, 3);
    #1;
    expg("rs_alloc", 0, 0);
    step();
    expg("rs_grant", 5'b00001, 5'b01000);
    next_cycle();
    reset = 1'b1;
    #1;
    expg("rs_pre", 5'b00001, 5'b01000);
    step();
    expg("rs_flush", 0, 0);
    check("rs_err", err, 0);
    check("rs_sel", out_sel, 0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) kill(i);
    #1;
    expg("rs_after", 0, 0);
    step();
    expg("rs_idle", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wormhole_switch_allocator.md
Name: wormhole_switch_allocator

Overview:
- Per-router switch allocator for the 5-port rr_router: LOCAL plus four mesh directions.
- Grants output ports to input ports packet by packet. An output stays locked to one input from head flit to tail flit, so packets never interleave on a link.
- When several inputs contend for the same output, a round-robin pointer per output chooses the winner.
- Sits between the routing_logic/ch_rx_logic outputs (requested direction per input) and the crossbar/tx stage (select and valid per output).

Parameters:
- NUM_PORTS, 5: number of router input ports and output ports.
- DIR_BITS, 3 (`BITS_DIR): width of one direction/port index.

Ports:
- clk  input  1  router clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_PORTS  input i holds a flit ready to forward.
- req_dir  input  NUM_PORTS*DIR_BITS  requested output for input i, at bits [i*DIR_BITS +: DIR_BITS]; valid only when req_valid[i].
- req_tail  input  NUM_PORTS  the current flit of input i is the packet tail. A single-flit packet has head=tail.
- out_busy  input  NUM_PORTS  the tx of output o cannot accept a flit this cycle.
- grant  output  NUM_PORTS  input i's flit is transferred this cycle; the input pops on grant.
- out_valid  output  NUM_PORTS  output o carries a flit this cycle.
- out_sel  output  NUM_PORTS*DIR_BITS  index of the input driving output o (crossbar select).
- err_bad_dir  output  1  sticky flag: a valid request carried req_dir >= NUM_PORTS.

Behaviour:
- Reset (synchronous, sampled at posedge clk):
  - all outputs go IDLE, owner=0, rr_ptr=NUM_PORTS-1 (so input 0 has first priority), err_bad_dir=0.
  - grant, out_valid and out_sel are 0 during and after reset until an allocation occurs.
- Per-output state: IDLE or LOCKED(owner). Each input can be owner of at most one output.
- IDLE, allocation:
  - Candidates are inputs i with req_valid[i], req_dir[i]==o, and i not owning any output.
  - Scan starts at rr_ptr+1 mod NUM_PORTS, first candidate wins.
  - At the edge the output goes LOCKED(winner) and rr_ptr<=winner.
  - No grant is issued in the allocation cycle. Head-to-first-grant latency is 1 cycle minimum.
- LOCKED(owner), grant and out_valid are combinational from registered state:
  - grant[owner] = out_valid[o] = req_valid[owner] && !out_busy[o].
  - out_sel[o] = owner whenever the output is LOCKED, and 0 when IDLE.
- Release: when grant[owner] && req_tail[owner], the output goes IDLE at the edge. It may reallocate from the following cycle.
  - Single-flit packet timeline: request at N, lock at edge N, grant at N+1, IDLE at N+2.
- Output busy while LOCKED: lock held, no grant, no loss.
- req_valid drops mid-packet (bubble): lock held, no grant.
- req_dir changes while the input owns an output: ignored; the input is still served only by its locked output.
- Bad direction: a request with req_dir >= NUM_PORTS is never a candidate and sets err_bad_dir, which stays set until reset.
- Simultaneous events:
  - Different outputs allocate independently in the same cycle.
  - Release and new allocation on the same output cannot both happen in one cycle: release takes priority, allocation follows next cycle.
- Reset mid-packet: all locks are dropped immediately. Upstream/downstream flush is the router's responsibility.
- Fairness: with continuous contention, a requester waits at most NUM_PORTS-1 packets.
- Invariants (assert in bench):
  - grant is one-hot per owner.
  - sum(grant) == sum(out_valid).
  - No two outputs share an owner.

Decomposition:
- Constants live in constants.v: port indices (LOCAL, NORTH, SOUTH, EAST, WEST), `BITS_DIR, NUM_PORTS.
- One sub-module, output_lock_arbiter: a single-output IDLE/LOCKED FSM plus round-robin pointer, instantiated NUM_PORTS times.
  - Owner-exclusion mask: the top level computes an "input owns an output" vector and feeds it to each instance.
- Expected size: about 200 lines total.

Test Plan:
- Single flit: reset, then in0 req_dir=2 with tail=1 at cycle 3 → grant[0] and out_valid[2] at cycle 4, out_sel[2]=0; output 2 IDLE at cycle 5.
- Contention: in1 and in3 both request output 4 with 3-flit packets → in1 wins first (ptr=4 after reset) with grants in cycles N+1..N+3; in3 is allocated at N+4 and granted N+5..N+7; rr_ptr=3 after.
- Backpressure: in0 locked to output 1, out_busy[1]=1 for 4 cycles mid-packet → grant[0]=0 and lock held throughout; flits resume the cycle busy falls.
- Independent outputs: in0→out1, in2→out3 and in4→out0 all at once → all three allocated in the same cycle; all grants in the next cycle with out_sel={..., out0:4, out1:0, out3:2}.
- Fairness: all 5 inputs continuously request output 0 with 1-flit packets → grants rotate 0,1,2,3,4,0 with one packet per 2 cycles.
- Bad direction / reset: in2 req_dir=6 → no grant and err_bad_dir=1; then reset is asserted mid-packet on a locked output → the next cycle has all grant=0, out_valid=0, err_bad_dir=0.
